user_regs_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing the CPU-side port of the user register bank among N_REQ requesters (CPU cores, DMA, debug).
- Write port: we/waddr/wdata. Read port: raddr/rdata, combinational in the bank.
- Serialises one access at a time through a 3-state FSM and returns a per-requester done pulse, read data and an error flag.

---
 rtl/user_regs_arb.sv | 191 +++++++++++++++++++
 tb/tb_user_regs_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_regs_arb.sv
// Round-robin arbiter and sequencer in front of the CPU port of the user register bank.
// Define USER_REGS_ARB_LOCK_EN to add i_lock for locked read-modify-write sequences.
module user_regs_arb #(
    parameter int N_REQ = 4,
    parameter int AW_W  = 6,
    parameter int AW_R  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_wr,
    input  logic [N_REQ*AW_W-1:0] i_addr,
    input  logic [N_REQ*32-1:0]   i_wdata,
`ifdef USER_REGS_ARB_LOCK_EN
    input  logic [N_REQ-1:0]      i_lock,
`endif
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_we_cpu,
    output logic [AW_W-1:0]       o_waddr_cpu,
    output logic [31:0]           o_wdata_cpu,
    output logic [AW_R-1:0]       o_raddr_cpu,
    input  logic [31:0]           i_rdata_cpu
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    state_t           state_d;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_d;
    logic [IW-1:0]    win;
    logic [IW:0]      scan;
    logic             found;
    logic             cmd_wr;
    logic             cmd_wr_d;
    logic [AW_W-1:0]  cmd_addr;
    logic [AW_W-1:0]  cmd_addr_d;
    logic [AW_W-1:0]  sel_addr;
    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] done_d;
    logic [31:0]      rdata_d;
    logic             err_d;
    logic             busy_d;
    logic             we_d;
    logic [AW_W-1:0]  waddr_d;
    logic [31:0]      wdata_d;
    logic [AW_R-1:0]  raddr_d;
`ifdef USER_REGS_ARB_LOCK_EN
    logic             lock;
    logic             lock_d;
`endif

    // Scan downward so the closest requester after ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        scan  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(N_REQ)) begin
                scan = scan - (IW+1)'(N_REQ);
            end
            if (i_req[scan[IW-1:0]]) begin
                found = 1'b1;
                win   = scan[IW-1:0];
            end
        end
`ifdef USER_REGS_ARB_LOCK_EN
        if (lock && i_lock[ptr]) begin
            found = i_req[ptr];
            win   = ptr;
        end
`endif
        sel_addr = i_addr[int'(win)*AW_W +: AW_W];
    end

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        cmd_wr_d   = cmd_wr;
        cmd_addr_d = cmd_addr;
        gnt_d      = '0;
        done_d     = '0;
        rdata_d    = '0;
        err_d      = 1'b0;
        busy_d     = 1'b0;
        we_d       = 1'b0;
        waddr_d    = '0;
        wdata_d    = '0;
        raddr_d    = '0;
`ifdef USER_REGS_ARB_LOCK_EN
        lock_d     = lock;
`endif
        unique case (state)
            IDLE: begin
`ifdef USER_REGS_ARB_LOCK_EN
                if (lock && !i_lock[ptr]) begin
                    lock_d = 1'b0;
                end
`endif
                if (found) begin
                    state_d    = ISSUE;
                    ptr_d      = win;
                    gnt_d      = N_REQ'(1) << win;
                    busy_d     = 1'b1;
                    cmd_wr_d   = i_wr[win];
                    cmd_addr_d = sel_addr;
                    if (i_wr[win]) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = i_wdata[int'(win)*32 +: 32];
                    end else begin
                        raddr_d = sel_addr[AW_R-1:0];
                    end
                end
            end
            ISSUE: begin
                state_d = DONE;
                gnt_d   = o_gnt;
                busy_d  = 1'b1;
                done_d  = o_gnt;
                // Reads beyond the externally written range return zero and flag an error.
                if (!cmd_wr) begin
                    if (|cmd_addr[AW_W-1:AW_R]) begin
                        err_d = 1'b1;
                    end else begin
                        rdata_d = i_rdata_cpu;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef USER_REGS_ARB_LOCK_EN
                if (i_lock[ptr]) begin
                    lock_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= IW'(N_REQ - 1);
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            o_gnt       <= '0;
            o_done      <= '0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_we_cpu    <= 1'b0;
            o_waddr_cpu <= '0;
            o_wdata_cpu <= '0;
            o_raddr_cpu <= '0;
`ifdef USER_REGS_ARB_LOCK_EN
            lock        <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cmd_wr      <= cmd_wr_d;
            cmd_addr    <= cmd_addr_d;
            o_gnt       <= gnt_d;
            o_done      <= done_d;
            o_rdata     <= rdata_d;
            o_err       <= err_d;
            o_busy      <= busy_d;
            o_we_cpu    <= we_d;
            o_waddr_cpu <= waddr_d;
            o_wdata_cpu <= wdata_d;
            o_raddr_cpu <= raddr_d;
`ifdef USER_REGS_ARB_LOCK_EN
            lock        <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_user_regs_arb.sv
// Bench for user_regs_arb: directed vector table, hand sequences and a random run
// checked against a transaction-level round-robin model.
module tb_user_regs_arb;

    localparam int N = 4;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [N-1:0] req;
    logic [N-1:0] wr;
    logic [N-1:0] lock;
    logic [N*6-1:0]  addr;
    logic [N*32-1:0] wdata;
    logic [N-1:0] o_gnt;
    logic [N-1:0] o_done;
    logic [31:0]  o_rdata;
    logic         o_err;
    logic         o_busy;
    logic         o_we_cpu;
    logic [5:0]   o_waddr_cpu;
    logic [31:0]  o_wdata_cpu;
    logic [2:0]   o_raddr_cpu;
    logic [31:0]  rdata_cpu;
    logic [31:0]  bank [8];

    int total = 0;
    int bad = 0;

    typedef struct {
        int          id;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    // random-phase model state
    int   cyc;
    int   ptr;
    int   free_cyc;
    int   iss_cyc;
    int   done_cyc;
    int   m_win;
    logic m_wr;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [N-1:0] seen_done;

    user_regs_arb #(.N_REQ(N), .AW_W(6), .AW_R(3)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (req),
        .i_wr        (wr),
        .i_addr      (addr),
        .i_wdata     (wdata),
`ifdef USER_REGS_ARB_LOCK_EN
        .i_lock      (lock),
`endif
        .o_gnt       (o_gnt),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_we_cpu    (o_we_cpu),
        .o_waddr_cpu (o_waddr_cpu),
        .o_wdata_cpu (o_wdata_cpu),
        .o_raddr_cpu (o_raddr_cpu),
        .i_rdata_cpu (rdata_cpu)
    );

    always #5 i_clk = ~i_clk;

    always_comb rdata_cpu = bank[o_raddr_cpu];

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int n, input logic w, input logic [5:0] a,
                           input logic [31:0] d);
        wr[n]          = w;
        addr[n*6 +: 6] = a;
        wdata[n*32 +: 32] = d;
        req[n]         = 1'b1;
    endtask

    task automatic do_reset();
        req   = '0;
        wr    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_gnt", o_gnt, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_we", o_we_cpu, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_err", o_err, 0);
        check("rst_wbus", {o_waddr_cpu, o_raddr_cpu, o_wdata_cpu[22:0]}, 0);
        i_rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [N-1:0] oh;
        oh = N'(1) << v.id;
        @(posedge i_clk);
        #1;
        set_cmd(v.id, v.wr, v.addr, v.wdata);
        @(negedge i_clk);
        check("v_idle_we", o_we_cpu, 0);
        check("v_idle_busy", o_busy, 0);
        @(negedge i_clk);
        check("v_iss_gnt", o_gnt, oh);
        check("v_iss_we", o_we_cpu, v.wr);
        check("v_iss_done", o_done, 0);
        if (v.wr) begin
            check("v_waddr", o_waddr_cpu, v.addr);
            check("v_wdata", o_wdata_cpu, v.wdata);
        end else begin
            check("v_raddr", o_raddr_cpu, v.addr[2:0]);
        end
        @(negedge i_clk);
        check("v_done", o_done, oh);
        check("v_rdata", o_rdata, v.rdata);
        check("v_err", o_err, v.err);
        check("v_done_we", o_we_cpu, 0);
        @(posedge i_clk);
        #1;
        req[v.id] = 1'b0;
        @(negedge i_clk);
        check("v_after_busy", o_busy, 0);
        check("v_after_gnt", o_gnt, 0);
        check("v_after_done", o_done, 0);
    endtask

    task automatic new_cmd(input int n);
        logic [5:0] a;
        a = $urandom_range(0, 1) ? 6'($urandom_range(0, 63))
                                 : 6'($urandom_range(0, 15));
        set_cmd(n, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic drive_rand();
        for (int n = 0; n < N; n++) begin
            if (seen_done[n]) begin
                if ($urandom_range(0, 1) == 1) new_cmd(n);
                else req[n] = 1'b0;
            end else if (!req[n]) begin
                if ($urandom_range(0, 2) == 0) new_cmd(n);
            end else if (cyc == iss_cyc && n == m_win &&
                         $urandom_range(0, 7) == 0) begin
                // owner walks away mid-access with a scrambled command
                req[n] = 1'b0;
                wr[n]  = ~wr[n];
                addr[n*6 +: 6] = 6'($urandom);
                wdata[n*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic model_step();
        logic        iss;
        logic        dn;
        logic [N-1:0] oh;
        int          w;
        iss = (cyc == iss_cyc);
        dn  = (cyc == done_cyc);
        oh  = N'(1) << m_win;
        check("r_gnt", o_gnt, (iss || dn) ? oh : '0);
        check("r_done", o_done, dn ? oh : '0);
        check("r_busy", o_busy, iss || dn);
        check("r_we", o_we_cpu, iss && m_wr);
        if (iss && m_wr) begin
            check("r_waddr", o_waddr_cpu, m_addr);
            check("r_wdata", o_wdata_cpu, m_wdata);
        end
        if (iss && !m_wr) check("r_raddr", o_raddr_cpu, m_addr[2:0]);
        if (dn) begin
            check("r_rdata", o_rdata,
                  (!m_wr && m_addr < 8) ? bank[m_addr[2:0]] : 32'h0);
            check("r_err", o_err, !m_wr && m_addr >= 8);
        end
        if (cyc >= free_cyc && req != '0) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                if (w < 0 && req[(ptr + i) % N]) w = (ptr + i) % N;
            end
            ptr      = w;
            m_win    = w;
            m_wr     = wr[w];
            m_addr   = addr[w*6 +: 6];
            m_wdata  = wdata[w*32 +: 32];
            iss_cyc  = cyc + 1;
            done_cyc = cyc + 2;
            free_cyc = cyc + 3;
        end
    endtask

    initial begin
        int nd1;
        int order [$];
        bank[0] = 32'hA0A0_0000;
        bank[1] = 32'h1111_0001;
        bank[2] = 32'h2222_0002;
        bank[3] = 32'h1234_5678;
        bank[4] = 32'h4444_0004;
        bank[5] = 32'h5555_0005;
        bank[6] = 32'h6666_0006;
        bank[7] = 32'hF00D_0007;

        vecs[0] = '{0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1] = '{2, 1'b0, 6'h03, 32'h0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1, 1'b0, 6'h0A, 32'h0, 32'h0, 1'b1};
        vecs[3] = '{3, 1'b1, 6'h3F, 32'h0BAD_F00D, 32'h0, 1'b0};
        vecs[4] = '{1, 1'b0, 6'h07, 32'h0, 32'hF00D_0007, 1'b0};
        vecs[5] = '{0, 1'b0, 6'h00, 32'h0, 32'hA0A0_0000, 1'b0};
        vecs[6] = '{3, 1'b0, 6'h3F, 32'h0, 32'h0, 1'b1};
        vecs[7] = '{2, 1'b1, 6'h08, 32'h8888_0008, 32'h0, 1'b0};
        vecs[8] = '{0, 1'b0, 6'h08, 32'h0, 32'h0, 1'b1};

        do_reset();
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // all requesters held high: strict rotation, one done per 3 cycles
        do_reset();
        @(posedge i_clk);
        #1;
        for (int n = 0; n < N; n++) set_cmd(n, 1'b0, 6'(n), 32'h0);
        for (int c = 0; c < 24; c++) begin
            @(negedge i_clk);
            if (c % 3 == 2) check("rr_done", o_done, N'(1) << ((c / 3) % N));
            else check("rr_gap", o_done, 0);
        end
        @(posedge i_clk);
        #1;
        req = '0;
        repeat (3) @(negedge i_clk);

        // reset in the middle of a write issue
        do_reset();
        @(posedge i_clk);
        #1;
        set_cmd(2, 1'b1, 6'h11, 32'hCAFE_F00D);
        @(negedge i_clk);
        @(negedge i_clk);
        check("ar_we_pre", o_we_cpu, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("ar_we", o_we_cpu, 0);
        check("ar_gnt", o_gnt, 0);
        check("ar_busy", o_busy, 0);
        check("ar_bus", {o_waddr_cpu, o_wdata_cpu[25:0]}, 0);
        req = '0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("ar_nodone", o_done, 0);
        end
        @(posedge i_clk);
        #1;
        set_cmd(0, 1'b0, 6'h01, 32'h0);
        set_cmd(1, 1'b0, 6'h02, 32'h0);
        set_cmd(3, 1'b0, 6'h04, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        check("ar_first", o_gnt, 4'b0001);
        @(negedge i_clk);
        check("ar_first_done", o_done, 4'b0001);
        @(posedge i_clk);
        #1;
        req[0] = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("ar_second", o_gnt, 4'b0010);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        req = '0;
        repeat (3) @(negedge i_clk);

`ifdef USER_REGS_ARB_LOCK_EN
        do_reset();
        run_vec(vecs[5]);
        @(posedge i_clk);
        #1;
        set_cmd(0, 1'b1, 6'h01, 32'h1111_1111);
        set_cmd(1, 1'b0, 6'h02, 32'h0);
        lock[1] = 1'b1;
        nd1 = 0;
        for (int c = 0; c < 30 && order.size() < 3; c++) begin
            @(negedge i_clk);
            seen_done = o_done;
            for (int n = 0; n < N; n++) if (o_done[n]) order.push_back(n);
            @(posedge i_clk);
            #1;
            if (o_gnt[1] && nd1 == 1) lock[1] = 1'b0;
            if (seen_done[1]) begin
                nd1++;
                if (nd1 == 1) set_cmd(1, 1'b1, 6'h02, 32'h2222_2222);
                else req[1] = 1'b0;
            end
            if (seen_done[0]) req[0] = 1'b0;
        end
        check("lk_count", order.size(), 3);
        if (order.size() == 3) begin
            check("lk_g0", order[0], 1);
            check("lk_g1", order[1], 1);
            check("lk_g2", order[2], 0);
        end
        req  = '0;
        lock = '0;
        repeat (3) @(negedge i_clk);
`endif

        // random traffic against the transaction-level model
        do_reset();
        ptr       = N - 1;
        free_cyc  = 0;
        iss_cyc   = -10;
        done_cyc  = -10;
        m_win     = 0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        seen_done = '0;
        for (cyc = 0; cyc < 600; cyc++) begin
            @(posedge i_clk);
            #1;
            drive_rand();
            @(negedge i_clk);
            model_step();
            seen_done = o_done;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
